// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin/amount constants, the change
// dispenser state encoding and the greedy amount-to-coins split.
package vm_pkg;

   localparam logic [4:0] AMT_5  = 5'd5;
   localparam logic [4:0] AMT_10 = 5'd10;
   localparam logic [4:0] AMT_15 = 5'd15;
   localparam logic [4:0] AMT_20 = 5'd20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_EJ10,
      ST_EJ5,
      ST_GAP,
      ST_DONE,
      ST_JAM
   } disp_state_t;

   typedef struct packed {
      logic [1:0] n10;
      logic [2:0] n5;
      logic       short_f;
   } coin_split_t;

   function automatic logic amount_ok(input logic [4:0] amt);
      return (amt == AMT_5) || (amt == AMT_10) || (amt == AMT_15) || (amt == AMT_20);
   endfunction

   // Greedy split: as many tens as the tube allows, fives for the rest.
   // Inventories arrive saturated (tens at 2, fives at 7), which is enough
   // because no payable amount needs more than that.
   function automatic coin_split_t split_amount(input logic [4:0] amt,
                                                input logic [1:0] inv10_sat,
                                                input logic [2:0] inv5_sat);
      coin_split_t s;
      logic [1:0]  want10;
      logic [4:0]  rest;
      want10    = (amt >= AMT_20) ? 2'd2 : (amt >= AMT_10) ? 2'd1 : 2'd0;
      s.n10     = (want10 < inv10_sat) ? want10 : inv10_sat;
      rest      = amt - ({3'b000, s.n10} * 5'd10);
      s.n5      = 3'(rest / 5'd5);
      s.short_f = (s.n5 > inv5_sat);
      return s;
   endfunction

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Coin hopper handshake: one level eject request per tube, one shared ack.
interface vm_change_dispenser_if;
   logic eject10;
   logic eject5;
   logic hopper_ack;

   modport master (output eject10, output eject5, input hopper_ack);
   modport slave  (input eject10, input eject5, output hopper_ack);
endinterface

// File: rtl/vm_tube_counter.sv
// One coin tube inventory: load from a refill, count down per released coin.
module vm_tube_counter #(
   parameter int INV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [INV_W-1:0] load_val,
   input  logic             dec,
   output logic [INV_W-1:0] count,
   output logic             is_zero
);

   assign is_zero = (count == '0);

   // Inventory register; an empty tube never wraps below zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && !is_zero)
         count <= count - INV_W'(1);
   end

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays a requested amount as 10 and 5 rupee coins through a
// two-tube hopper, one coin per handshake, with jam detection by timeout.
// Optional build macro VM_CHANGE_AUDIT_EN adds paid_total and audit_tick.
module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int INV_W       = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4:0]            change,
   vm_change_dispenser_if.master hop,
   input  logic                  refill_10,
   input  logic                  refill_5,
   input  logic [INV_W-1:0]      refill_cnt,
   input  logic                  jam_clr,
   output logic                  busy,
   output logic                  done,
   output logic                  short,
   output logic                  invalid,
   output logic                  overrun,
   output logic                  jam,
`ifdef VM_CHANGE_AUDIT_EN
   output logic [15:0]           paid_total,
   output logic                  audit_tick,
`endif
   output logic [INV_W-1:0]      inv10,
   output logic [INV_W-1:0]      inv5
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   disp_state_t state, nxt;
   logic [4:0]    amount;
   logic [1:0]    rem10;
   logic [2:0]    rem5;
   logic [TW-1:0] tcnt;
   logic          eject10_r, eject5_r;
   logic          short_n, invalid_n, overrun_n;
   logic          zero10, zero5;
   logic [1:0]    inv10_sat;
   logic [2:0]    inv5_sat;
   coin_split_t   split;
   logic          req, ack10, ack5, timeout;

   assign hop.eject10 = eject10_r;
   assign hop.eject5  = eject5_r;

   assign req       = (change != 5'd0);
   assign inv10_sat = (inv10 > INV_W'(2)) ? 2'd2 : inv10[1:0];
   assign inv5_sat  = (inv5 > INV_W'(7)) ? 3'd7 : inv5[2:0];
   assign split     = split_amount(amount, inv10_sat, inv5_sat);
   assign ack10     = (state == ST_EJ10) && hop.hopper_ack && (rem10 != 2'd0) && !zero10;
   assign ack5      = (state == ST_EJ5) && hop.hopper_ack && (rem5 != 3'd0) && !zero5;
   assign timeout   = (tcnt == TW'(ACK_TIMEOUT));

   vm_tube_counter #(.INV_W(INV_W)) u_tube10 (
      .clk      (clk),
      .reset    (reset),
      .load     ((state == ST_IDLE) && refill_10),
      .load_val (refill_cnt),
      .dec      (ack10),
      .count    (inv10),
      .is_zero  (zero10)
   );

   vm_tube_counter #(.INV_W(INV_W)) u_tube5 (
      .clk      (clk),
      .reset    (reset),
      .load     ((state == ST_IDLE) && refill_5),
      .load_val (refill_cnt),
      .dec      (ack5),
      .count    (inv5),
      .is_zero  (zero5)
   );

   // Next-state and next-pulse decode; an ack wins over a same-cycle timeout.
   always_comb begin
      nxt       = state;
      short_n   = 1'b0;
      invalid_n = 1'b0;
      overrun_n = req && (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (amount_ok(change)) nxt = ST_CHECK;
               else                   invalid_n = 1'b1;
            end
         end
         ST_CHECK: begin
            if (split.short_f) begin
               nxt     = ST_IDLE;
               short_n = 1'b1;
            end else if (split.n10 != 2'd0) begin
               nxt = ST_EJ10;
            end else begin
               nxt = ST_EJ5;
            end
         end
         ST_EJ10: begin
            if (ack10)        nxt = ST_GAP;
            else if (timeout) nxt = ST_JAM;
         end
         ST_EJ5: begin
            if (ack5)         nxt = ST_GAP;
            else if (timeout) nxt = ST_JAM;
         end
         ST_GAP: begin
            if (rem10 != 2'd0)     nxt = ST_EJ10;
            else if (rem5 != 3'd0) nxt = ST_EJ5;
            else                   nxt = ST_DONE;
         end
         ST_DONE: nxt = ST_IDLE;
         ST_JAM:  if (jam_clr) nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   // State, registered outputs, remaining coin counts and the ack timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         eject10_r <= 1'b0;
         eject5_r  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         short     <= 1'b0;
         invalid   <= 1'b0;
         overrun   <= 1'b0;
         jam       <= 1'b0;
         rem10     <= '0;
         rem5      <= '0;
         tcnt      <= '0;
      end else begin
         state     <= nxt;
         eject10_r <= (nxt == ST_EJ10);
         eject5_r  <= (nxt == ST_EJ5);
         busy      <= (nxt != ST_IDLE) && (nxt != ST_JAM);
         done      <= (nxt == ST_DONE);
         jam       <= (nxt == ST_JAM);
         short     <= short_n;
         invalid   <= invalid_n;
         overrun   <= overrun_n;
         if (state == ST_CHECK) begin
            rem10 <= split.n10;
            rem5  <= split.n5;
         end else if (state == ST_JAM) begin
            rem10 <= '0;
            rem5  <= '0;
         end else begin
            if (ack10) rem10 <= rem10 - 2'd1;
            if (ack5)  rem5  <= rem5 - 3'd1;
         end
         if ((nxt == state) && ((state == ST_EJ10) || (state == ST_EJ5)))
            tcnt <= tcnt + TW'(1);
         else
            tcnt <= '0;
      end
   end

   // Requested amount, captured only when a valid request is accepted.
   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && (nxt == ST_CHECK))
         amount <= change;
   end

`ifdef VM_CHANGE_AUDIT_EN
   // Running total of rupees actually released, one tick per accepted coin.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         paid_total <= 16'd0;
         audit_tick <= 1'b0;
      end else begin
         audit_tick <= ack10 || ack5;
         if (ack10)     paid_total <= paid_total + 16'd10;
         else if (ack5) paid_total <= paid_total + 16'd5;
      end
   end
`endif

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Scoreboard bench for vm_change_dispenser: a payout model predicts the coin,
// done/short/invalid/jam event stream; a monitor pops and compares it.
`timescale 1ns/1ps
module tb_vm_change_dispenser;

   localparam int INV_W       = 8;
   localparam int ACK_TIMEOUT = 255;
   localparam int EV_C10   = 1;
   localparam int EV_C5    = 2;
   localparam int EV_DONE  = 3;
   localparam int EV_SHORT = 4;
   localparam int EV_INV   = 5;
   localparam int EV_JAM   = 6;

   typedef struct {
      int kind;
      int i10;
      int i5;
   } ev_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [4:0]       change = 5'd0;
   logic             refill_10 = 1'b0;
   logic             refill_5 = 1'b0;
   logic [INV_W-1:0] refill_cnt = '0;
   logic             jam_clr = 1'b0;
   logic             busy, done, short, invalid, overrun, jam;
   logic [INV_W-1:0] inv10, inv5;
`ifdef VM_CHANGE_AUDIT_EN
   logic [15:0]      paid_total;
   logic             audit_tick;
`endif

   vm_change_dispenser_if ifc ();

   vm_change_dispenser #(.INV_W(INV_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .change     (change),
      .hop        (ifc),
      .refill_10  (refill_10),
      .refill_5   (refill_5),
      .refill_cnt (refill_cnt),
      .jam_clr    (jam_clr),
      .busy       (busy),
      .done       (done),
      .short      (short),
      .invalid    (invalid),
      .overrun    (overrun),
      .jam        (jam),
`ifdef VM_CHANGE_AUDIT_EN
      .paid_total (paid_total),
      .audit_tick (audit_tick),
`endif
      .inv10      (inv10),
      .inv5       (inv5)
   );

   int   checks = 0;
   int   failures = 0;
   ev_t  sb_q[$];
   int   ovr_q[$];
   int   m_inv10 = 0;
   int   m_inv5 = 0;
   int   hop_mode = 0;   // 0: random delay plus stray acks, 1: immediate ack, 2: hopper dead
   int   amt_tbl [14] = '{5, 10, 15, 20, 5, 10, 15, 20, 3, 7, 12, 25, 31, 1};

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_ev(input int k);
      ev_t e;
      e.kind = k;
      e.i10  = m_inv10;
      e.i5   = m_inv5;
      sb_q.push_back(e);
   endtask

   // Reference payout: greedy tens limited by stock, fives for the remainder.
   task automatic model_req(input int amt);
      int n10, n5;
      if (amt == 0) return;
      if (!(amt == 5 || amt == 10 || amt == 15 || amt == 20)) begin
         push_ev(EV_INV);
         return;
      end
      n10 = amt / 10;
      if (n10 > m_inv10) n10 = m_inv10;
      n5 = (amt - 10 * n10) / 5;
      if (n5 > m_inv5) begin
         push_ev(EV_SHORT);
         return;
      end
      for (int i = 0; i < n10; i++) push_ev(EV_C10);
      for (int i = 0; i < n5; i++) push_ev(EV_C5);
      m_inv10 -= n10;
      m_inv5  -= n5;
      push_ev(EV_DONE);
   endtask

   task automatic sb_check(input int kind);
      ev_t e;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard: got event %0d, expected no event", kind);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind ||
             ((kind == EV_DONE || kind == EV_SHORT || kind == EV_JAM) &&
              (inv10 !== INV_W'(e.i10) || inv5 !== INV_W'(e.i5)))) begin
            failures++;
            $display("FAIL scoreboard: got event %0d inv10=%0d inv5=%0d, expected event %0d inv10=%0d inv5=%0d",
                     kind, inv10, inv5, e.kind, e.i10, e.i5);
         end
      end
   endtask

   // Hopper model: answers eject requests after a random delay.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      ifc.hopper_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if ((ifc.eject10 || ifc.eject5) && hop_mode != 2) begin
            if (hop_mode == 1 || wait_cnt == 0) begin
               ifc.hopper_ack = 1'b1;
               wait_cnt = $urandom_range(0, 3);
            end else begin
               ifc.hopper_ack = 1'b0;
               wait_cnt--;
            end
         end else if (hop_mode == 0) begin
            ifc.hopper_ack = ($urandom_range(0, 3) == 0);
         end else begin
            ifc.hopper_ack = 1'b0;
         end
      end
   end

   // Monitor: every observable DUT event is popped from the scoreboard.
   initial begin
      logic jam_q;
      jam_q = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            jam_q = 1'b0;
         end else begin
            if (ifc.eject10 && ifc.hopper_ack) sb_check(EV_C10);
            if (ifc.eject5 && ifc.hopper_ack)  sb_check(EV_C5);
            if (done)                          sb_check(EV_DONE);
            if (short)                         sb_check(EV_SHORT);
            if (invalid)                       sb_check(EV_INV);
            if (jam && !jam_q)                 sb_check(EV_JAM);
            jam_q = jam;
            if (overrun) begin
               checks++;
               if (ovr_q.size() == 0) begin
                  failures++;
                  $display("FAIL overrun: got pulse, expected none");
               end else begin
                  void'(ovr_q.pop_front());
               end
            end
         end
      end
   end

   task automatic send(input int amt);
      @(negedge clk);
      change = 5'(amt);
      @(negedge clk);
      change = 5'd0;
   endtask

   task automatic refill(input bit r10, input bit r5, input int cnt);
      @(negedge clk);
      refill_10  = r10;
      refill_5   = r5;
      refill_cnt = INV_W'(cnt);
      @(negedge clk);
      refill_10 = 1'b0;
      refill_5  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((busy || sb_q.size() != 0) && n < 2000);
      check_eq("idle_reached", (n < 2000), 1);
   endtask

   task automatic wait_eject10();
      int n;
      n = 0;
      while (!ifc.eject10 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("eject10_seen", ifc.eject10, 1);
   endtask

   initial begin
      int cyc;
      int a, b, amt;
      logic saw_last;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_eject10", ifc.eject10, 0);
      check_eq("rst_eject5", ifc.eject5, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_pulses", {done, short, invalid, overrun}, 0);
      check_eq("rst_jam", jam, 0);
      check_eq("rst_inv10", inv10, 0);
      check_eq("rst_inv5", inv5, 0);
      reset = 1'b0;

      // 15 from a 5/5 stock: one ten then one five
      refill(1, 1, 5); m_inv10 = 5; m_inv5 = 5;
      check_eq("refill_inv10", inv10, 5);
      check_eq("refill_inv5", inv5, 5);
      model_req(15); send(15); wait_idle();
      check_eq("a_inv10", inv10, 4);
      check_eq("a_inv5", inv5, 4);

      // 20 with no tens: four fives
      refill(1, 0, 0); m_inv10 = 0;
      refill(0, 1, 4); m_inv5 = 4;
      model_req(20); send(20); wait_idle();
      check_eq("b_inv5", inv5, 0);

      // 15 with one ten and no fives: short in cycle 2, nothing paid
      refill(1, 0, 1); m_inv10 = 1;
      model_req(15); send(15);
      check_eq("short_c1", short, 0);
      check_eq("busy_c1", busy, 1);
      @(negedge clk);
      check_eq("short_c2", short, 1);
      check_eq("no_eject_c2", {ifc.eject10, ifc.eject5}, 0);
      wait_idle();
      check_eq("c_inv10", inv10, 1);
      check_eq("c_inv5", inv5, 0);

      // Invalid amount
      model_req(7); send(7); wait_idle();

      // Overrun while a ten is being ejected; payout still completes
      refill(1, 1, 5); m_inv10 = 5; m_inv5 = 5;
      model_req(20); send(20);
      wait_eject10();
      ovr_q.push_back(1);
      change = 5'd10;
      @(negedge clk);
      change = 5'd0;
      wait_idle();
      check_eq("ovr_inv10", inv10, 3);

      // Minimum 20 payout latency with immediate acks
      hop_mode = 1;
      model_req(20); send(20);
      cyc = 1;
      while (!done && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("done_latency", cyc, 6);
      wait_idle();
      hop_mode = 0;

      // Dead hopper during a five: jam, then recovery
      refill(1, 0, 0); m_inv10 = 0;
      hop_mode = 2;
      push_ev(EV_JAM);
      send(5);
      cyc = 1;
      saw_last = 1'b0;
      while (!jam && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == ACK_TIMEOUT + 2) saw_last = ifc.eject5;
      end
      check_eq("jam_cycle", cyc, ACK_TIMEOUT + 3);
      check_eq("eject5_last_wait", saw_last, 1);
      check_eq("jam_eject5", ifc.eject5, 0);
      check_eq("jam_busy", busy, 0);
      ovr_q.push_back(1);
      send(10);
      refill(0, 1, 9);
      check_eq("jam_refill_ignored", inv5, 5);
      @(negedge clk); jam_clr = 1'b1;
      @(negedge clk); jam_clr = 1'b0;
      check_eq("jam_cleared", jam, 0);
      hop_mode = 0;
      model_req(5); send(5); wait_idle();
      check_eq("after_jam_inv5", inv5, 4);

      // Reset while a ten is being ejected
      refill(1, 0, 3); m_inv10 = 3;
      hop_mode = 2;
      send(10);
      wait_eject10();
      #2 reset = 1'b1;
      #1;
      check_eq("arst_eject10", ifc.eject10, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_inv10", inv10, 0);
      check_eq("arst_inv5", inv5, 0);
      sb_q.delete();
      m_inv10 = 0; m_inv5 = 0;
      @(negedge clk);
      reset = 1'b0;
      hop_mode = 0;
      refill(1, 0, 2); m_inv10 = 2;
      model_req(10); send(10); wait_idle();
      check_eq("post_rst_inv10", inv10, 1);

      // Randomized requests and refills
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            refill(1, 0, a); m_inv10 = a;
            refill(0, 1, b); m_inv5 = b;
         end
         amt = amt_tbl[$urandom_range(0, 13)];
         model_req(amt); send(amt); wait_idle();
         check_eq("rand_inv10", inv10, m_inv10);
         check_eq("rand_inv5", inv5, m_inv5);
      end

      repeat (3) @(negedge clk);
      check_eq("sb_drained", sb_q.size(), 0);
      check_eq("ovr_drained", ovr_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
